// File: rtl/gal_olmc_bank_if.sv
// Per-channel term, enable and feedback bundle shared between the AND array and the OLMC bank.
// The pads stay a plain inout on the bank because they are bidirectional nets.
interface gal_olmc_bank_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] E;
    logic [WIDTH-1:0] FB;

    modport master (output A, output E, input FB);
    modport slave  (input A, input E, output FB);
endinterface

// File: rtl/gal_olmc_bank.sv
// Bank of GAL output logic macrocells: each channel is combinational, D or T registered,
// with optional inversion, a tristate pad and feedback into the AND array.

module gal_olmc_cell #(
    parameter bit REG = 1'b0,
    parameter bit TOG = 1'b0,
    parameter bit INV = 1'b0
) (
    input  logic C,
    input  logic R,
    input  logic SP,
    input  logic CE,
    input  logic i_a,
    output logic o_q
);
    logic w_d;

    assign w_d = INV ? ~i_a : i_a;

    if (REG) begin : g_reg
        logic r_q;

        // Reset beats preset beats enable; R and SP act regardless of CE.
        always_ff @(posedge C) begin
            if (R)
                r_q <= 1'b0;
            else if (SP)
                r_q <= 1'b1;
            else if (CE)
                r_q <= TOG ? (r_q ^ w_d) : w_d;
        end

        assign o_q = r_q;
    end else begin : g_comb
        // Clock and controls have no meaning for a combinational macrocell.
        logic w_unused;
        assign w_unused = &{C, R, SP, CE};
        assign o_q      = w_d;
    end
endmodule

module gal_olmc_bank #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] REGISTERED = '0,
    parameter logic [WIDTH-1:0] TOGGLE     = '0,
    parameter logic [WIDTH-1:0] INVERTED   = '0
) (
    input  logic               C,
    input  logic               R,
    input  logic               SP,
    input  logic               CE,
    gal_olmc_bank_if.slave     bus,
    inout  wire  [WIDTH-1:0]   Y
);
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_fb;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        gal_olmc_cell #(
            .REG (REGISTERED[i]),
            .TOG (TOGGLE[i]),
            .INV (INVERTED[i])
        ) u_cell (
            .C   (C),
            .R   (R),
            .SP  (SP),
            .CE  (CE),
            .i_a (bus.A[i]),
            .o_q (w_q[i])
        );

        assign Y[i] = bus.E[i] ? w_q[i] : 1'bz;

        // A combinational pad doubles as an input when disabled, so feed back the net itself.
        if (REGISTERED[i]) begin : g_fb_reg
            assign w_fb[i] = w_q[i];
        end else begin : g_fb_pad
            assign w_fb[i] = Y[i];
        end
    end

    assign bus.FB = w_fb;
endmodule
